// File: rtl/dsram_responder.sv
// dsram_responder: data SRAM slave with byte-lane writes and an RD_LAT-deep read pipeline.
// Ports: soc_clk/resetn (async active-low); data_sram_en/wen/addr/wdata request;
// data_sram_rdata/rdata_valid/resp_err read response; wr_err out-of-range write pulse;
// rd_cnt/wr_cnt statistics, built only when DSRAM_STAT_EN is defined (else tied to 0).
module dsram_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        soc_clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        resp_err,
  output logic        wr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be in 1..4");
  end
  logic [31:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic in_range, rd, wr_ok, wr_bad, unused_ok;
  logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d;
  logic [31:0] dat_q [RD_LAT];
  logic [31:0] dat_d [RD_LAT];
  logic wr_err_q, wr_err_d;
  assign idx       = data_sram_addr[ADDR_W+1:2];
  assign in_range  = (data_sram_addr >> (ADDR_W + 2)) == 32'd0;
  assign rd        = data_sram_en && data_sram_wen == 4'd0;
  assign wr_ok     = data_sram_en && data_sram_wen != 4'd0 && in_range;
  assign wr_bad    = data_sram_en && data_sram_wen != 4'd0 && !in_range;
  assign unused_ok = ^data_sram_addr[1:0];
  always_ff @(posedge soc_clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_ok && data_sram_wen[i]) mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
  // Data/err stages advance only behind a valid bit, so the last stage
  // holds the previous result while no read is emerging.
  always_comb begin
    wr_err_d = wr_bad;
    vld_d    = '0;
    err_d    = err_q;
    dat_d    = dat_q;
    vld_d[0] = rd;
    if (rd) begin
      dat_d[0] = in_range ? mem_q[idx] : 32'd0;
      err_d[0] = !in_range;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end
  always_ff @(posedge soc_clk or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= '0;
      err_q    <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= 32'd0;
    end else begin
      vld_q    <= vld_d;
      err_q    <= err_d;
      wr_err_q <= wr_err_d;
      dat_q    <= dat_d;
    end
  end
  assign data_sram_rdata = dat_q[RD_LAT-1];
  assign rdata_valid     = vld_q[RD_LAT-1];
  assign resp_err        = vld_q[RD_LAT-1] & err_q[RD_LAT-1];
  assign wr_err          = wr_err_q;
`ifdef DSRAM_STAT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  always_comb begin
    rd_cnt_d = (rdata_valid && ~&rd_cnt_q) ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = (wr_ok && ~&wr_cnt_q) ? wr_cnt_q + 32'd1 : wr_cnt_q;
  end
  always_ff @(posedge soc_clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'd0;
  assign wr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: scoreboard bench driving four instances (RD_LAT 1..4) in lockstep.
module tb_dsram_responder;
  typedef struct packed {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata [4];
  logic        valid [4];
  logic        rerr [4];
  logic        werr [4];
  logic [31:0] rcnt [4];
  logic [31:0] wcnt [4];
  exp_t        sb [4][$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : g_lat
    dsram_responder #(.ADDR_W(10), .RD_LAT(g + 1)) u (
      .soc_clk(clk), .resetn(resetn),
      .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata[g]), .rdata_valid(valid[g]), .resp_err(rerr[g]), .wr_err(werr[g]),
      .rd_cnt(rcnt[g]), .wr_cnt(wcnt[g])
    );
  end
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (valid[k]) begin
        n_tests++;
        if (sb[k].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid lat%0d: got data %h err %0d at cycle %0d, required no response", k + 1, rdata[k], rerr[k], cyc);
        end else begin
          exp_t x;
          x = sb[k].pop_front();
          if (rdata[k] !== x.d || rerr[k] !== x.e || cyc != x.c) begin
            n_fail++;
            $display("FAIL resp lat%0d: got data %h err %0d cycle %0d, required data %h err %0d cycle %0d", k + 1, rdata[k], rerr[k], cyc, x.d, x.e, x.c);
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask
  task automatic go(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #2;
    en = e; wen = w; addr = a; wdata = wd;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w);
    go(1'b1, w, a, wd);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    go(1'b1, 4'd0, a, 32'd0);
    for (int k = 0; k < 4; k++) sb[k].push_back('{d: ed, e: ee, c: cyc + k + 1});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask
  task automatic chk_zero(input string tag);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_rdata lat%0d", tag, k + 1), rdata[k], 32'd0);
      chk($sformatf("%s_valid lat%0d", tag, k + 1), {31'd0, valid[k]}, 32'd0);
      chk($sformatf("%s_err lat%0d", tag, k + 1), {30'd0, rerr[k], werr[k]}, 32'd0);
      chk($sformatf("%s_cnt lat%0d", tag, k + 1), rcnt[k] | wcnt[k], 32'd0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    chk_zero("reset");
    // byte lanes
    wr(32'h10, 32'hAABB_CCDD, 4'hF);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    rd(32'h10, 32'hAA22_CC44, 1'b0);
    // streaming
    wr(32'h0, 32'h0, 4'hF);
    wr(32'h4, 32'h1, 4'hF);
    wr(32'h8, 32'h2, 4'hF);
    wr(32'hC, 32'h3, 4'hF);
    rd(32'h0, 32'h0, 1'b0);
    rd(32'h4, 32'h1, 1'b0);
    rd(32'h8, 32'h2, 1'b0);
    rd(32'hC, 32'h3, 1'b0);
    idle(5);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("hold_idle lat%0d", k + 1), rdata[k], 32'h3);
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    idle(1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("hold_write lat%0d", k + 1), rdata[k], 32'h3);
    // range errors
    wr(32'h1000, 32'hFFFF_FFFF, 4'hF);
    idle(1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("wr_err_pulse lat%0d", k + 1), {31'd0, werr[k]}, 32'd1);
    idle(1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("wr_err_clear lat%0d", k + 1), {31'd0, werr[k]}, 32'd0);
    rd(32'h0, 32'h0, 1'b0);
    rd(32'h1000, 32'h0, 1'b1);
    rd(32'h8000_0010, 32'h0, 1'b1);
    wr(32'hFFC, 32'h1234_5678, 4'hF);
    rd(32'hFFC, 32'h1234_5678, 1'b0);
    rd(32'h13, 32'hAA22_CC44, 1'b0);
    // ordering around writes
    wr(32'h20, 32'h5, 4'hF);
    rd(32'h20, 32'h5, 1'b0);
    rd(32'h20, 32'h5, 1'b0);
    wr(32'h20, 32'h9, 4'hF);
    rd(32'h20, 32'h9, 1'b0);
    idle(6);
    // reset with reads in flight: neither read may ever respond
    go(1'b1, 4'd0, 32'h10, 32'd0);
    @(posedge clk);
    #2 resetn = 1'b0; addr = 32'h20;
    @(posedge clk);
    #2 resetn = 1'b1; en = 1'b0;
    chk_zero("post_reset");
    idle(6);
    rd(32'h10, 32'hAA22_CC44, 1'b0);
    rd(32'h20, 32'h9, 1'b0);
    idle(6);
    // counters
    @(posedge clk);
    #2 resetn = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    wr(32'h30, 32'h1, 4'hF);
    wr(32'h34, 32'h2, 4'hF);
    wr(32'h38, 32'h3, 4'hF);
    wr(32'h2000, 32'h7, 4'hF);
    rd(32'h30, 32'h1, 1'b0);
    rd(32'h34, 32'h2, 1'b0);
    rd(32'h38, 32'h3, 1'b0);
    rd(32'h2000, 32'h0, 1'b1);
    rd(32'h10, 32'hAA22_CC44, 1'b0);
    idle(7);
    @(negedge clk);
`ifdef DSRAM_STAT_EN
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_cnt lat%0d", k + 1), wcnt[k], 32'd3);
      chk($sformatf("rd_cnt lat%0d", k + 1), rcnt[k], 32'd5);
    end
    @(posedge clk);
    #2 g_lat[0].u.rd_cnt_q = 32'hFFFF_FFFE;
    rd(32'h30, 32'h1, 1'b0);
    rd(32'h34, 32'h2, 1'b0);
    rd(32'h38, 32'h3, 1'b0);
    idle(7);
    @(negedge clk);
    chk("rd_cnt_saturate lat1", rcnt[0], 32'hFFFF_FFFF);
`else
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_cnt_off lat%0d", k + 1), wcnt[k], 32'd0);
      chk($sformatf("rd_cnt_off lat%0d", k + 1), rcnt[k], 32'd0);
    end
`endif
    idle(8);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("missing_resp lat%0d", k + 1), sb[k].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
